buffer_shift_ctrl: RTL

BUFFER_SHIFT_CTRL -- requirements
Module: buffer_shift_ctrl

---
 rtl/buffer_shift_ctrl_if.sv | 33 +++
 rtl/buffer_shift_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/buffer_shift_ctrl_if.sv
// Handshake and configuration bundle between the row sequencer and its host/downstream logic.
interface buffer_shift_ctrl_if #(
    parameter int unsigned X_MAC      = 4,
    parameter int unsigned MUXCONTROL = 4,
    parameter int unsigned ADDR_W     = 10
);
    logic                    start;
    logic                    pad;
    logic [7:0]              num_words;
    logic [ADDR_W-1:0]       base_addr;
    logic [X_MAC*2-1:0]      buffermux_cfg;
    logic [X_MAC-1:0]        iszero_cfg;
    logic                    stall;
    logic                    busy;
    logic                    done;
    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic [MUXCONTROL-1:0]   control;
    logic [X_MAC*2-1:0]      buffermux;
    logic [X_MAC-1:0]        iszero;

    // Host side: issues requests and configuration, observes status.
    modport master (
        output start, pad, num_words, base_addr, buffermux_cfg, iszero_cfg, stall,
        input  busy, done, rd_en, rd_addr, control, buffermux, iszero
    );

    // Sequencer side.
    modport slave (
        input  start, pad, num_words, base_addr, buffermux_cfg, iszero_cfg, stall,
        output busy, done, rd_en, rd_addr, control, buffermux, iszero
    );
endinterface

// File: rtl/buffer_shift_ctrl.sv
// Row sequencer: reads each word of a row from buffer memory and, one cycle later,
// issues the matching shift-register op code; padded rows append two end codes.
module buffer_shift_ctrl #(
    parameter int unsigned X_MAC      = 4,
    parameter int unsigned MUXCONTROL = 4,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic               clk,
    input  logic               rst,
    buffer_shift_ctrl_if.slave bus
);

    localparam logic [MUXCONTROL-1:0] CodePadInit1  = MUXCONTROL'(0);
    localparam logic [MUXCONTROL-1:0] CodePadUinit1 = MUXCONTROL'(2);
    localparam logic [MUXCONTROL-1:0] CodePadUinit2 = MUXCONTROL'(3);
    localparam logic [MUXCONTROL-1:0] CodeUpadInit1 = MUXCONTROL'(4);
    localparam logic [MUXCONTROL-1:0] CodeUpadUinit1 = MUXCONTROL'(6);
    localparam logic [MUXCONTROL-1:0] CodeUpadUinit2 = MUXCONTROL'(7);
    localparam logic [MUXCONTROL-1:0] CodePadEnd3   = MUXCONTROL'(8);
    localparam logic [MUXCONTROL-1:0] CodePadEnd4   = MUXCONTROL'(9);
    localparam logic [MUXCONTROL-1:0] CodeHold      = MUXCONTROL'(15);

    typedef enum logic [2:0] {StIdle, StRun, StEnd3, StEnd4, StFin} state_e;

    state_e state_q, state_d;

    // rd_cnt: next word to read; code_cnt: next word whose code is due.
    logic [7:0]            rd_cnt_q, rd_cnt_d;
    logic [7:0]            code_cnt_q, code_cnt_d;
    logic [7:0]            num_q, num_d;
    logic                  pad_q, pad_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [MUXCONTROL-1:0] control_q, control_d;
    logic [X_MAC*2-1:0]    buffermux_q, buffermux_d;
    logic [X_MAC-1:0]      iszero_q, iszero_d;

    function automatic logic [MUXCONTROL-1:0] word_code(input logic [7:0] k, input logic pad);
        logic [MUXCONTROL-1:0] c;
        if (k == 8'd0) begin
            c = pad ? CodePadInit1 : CodeUpadInit1;
        end else if (k[0]) begin
            c = pad ? CodePadUinit1 : CodeUpadUinit1;
        end else begin
            c = pad ? CodePadUinit2 : CodeUpadUinit2;
        end
        return c;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stall freezes every state except IDLE and FIN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = (bus.num_words == 8'd0) ? StFin : StRun;
                end
            end
            StRun: begin
                if (!bus.stall && (code_cnt_q == num_q)) begin
                    state_d = pad_q ? StEnd3 : StFin;
                end
            end
            StEnd3: begin
                if (!bus.stall) begin
                    state_d = StEnd4;
                end
            end
            StEnd4: begin
                if (!bus.stall) begin
                    state_d = StFin;
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values; outputs are registered so each code trails its read.
    always_comb begin
        rd_cnt_d    = rd_cnt_q;
        code_cnt_d  = code_cnt_q;
        num_d       = num_q;
        pad_d       = pad_q;
        base_d      = base_q;
        rd_addr_d   = rd_addr_q;
        buffermux_d = buffermux_q;
        iszero_d    = iszero_q;
        rd_en_d     = 1'b0;
        control_d   = CodeHold;
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StFin) && (state_q != StFin);
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    num_d       = bus.num_words;
                    pad_d       = bus.pad;
                    base_d      = bus.base_addr;
                    buffermux_d = bus.buffermux_cfg;
                    iszero_d    = bus.iszero_cfg;
                    rd_cnt_d    = 8'd0;
                    code_cnt_d  = 8'd0;
                    if (bus.num_words != 8'd0) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = bus.base_addr;
                        rd_cnt_d  = 8'd1;
                    end
                end
            end
            StRun: begin
                if (!bus.stall) begin
                    if (rd_cnt_q < num_q) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_q + ADDR_W'(rd_cnt_q);
                        rd_cnt_d  = rd_cnt_q + 8'd1;
                    end
                    if (code_cnt_q < rd_cnt_q) begin
                        control_d  = word_code(code_cnt_q, pad_q);
                        code_cnt_d = code_cnt_q + 8'd1;
                    end else if (pad_q) begin
                        control_d = CodePadEnd3;
                    end
                end
            end
            StEnd3: begin
                if (!bus.stall) begin
                    control_d = CodePadEnd4;
                end
            end
            StEnd4, StFin: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q    <= '0;
            code_cnt_q  <= '0;
            num_q       <= '0;
            pad_q       <= 1'b0;
            base_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            control_q   <= CodeHold;
            buffermux_q <= '0;
            iszero_q    <= '0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            code_cnt_q  <= code_cnt_d;
            num_q       <= num_d;
            pad_q       <= pad_d;
            base_q      <= base_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            control_q   <= control_d;
            buffermux_q <= buffermux_d;
            iszero_q    <= iszero_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.control   = control_q;
    assign bus.buffermux = buffermux_q;
    assign bus.iszero    = iszero_q;

endmodule
